// File: rtl/astat_reg.sv
// -----------------------------------------------------------------------------
// astat_reg -- arithmetic status register with sticky overflows and a LIFO
// status stack.
//
// ASTAT collects the per-unit result flags. Each field group (ALU, multiplier,
// shifter) updates only when its enable is high. ASTAT can also be written
// explicitly or reloaded from the status stack. Sticky overflow bits collect
// overflow events until they are rewritten. Every output comes from a flop.
//
// Ports
//   clk          in   system clock; all state changes on the rising edge
//   reset        in   asynchronous, active-high reset
//   alu_flg_en   in   ALU flag update strobe
//   alu_flg[3:0] in   {ac, an, av, az}
//   mul_flg_en   in   multiplier flag update strobe
//   mul_flg[1:0] in   {mv, mn}
//   shf_flg_en   in   shifter flag update strobe
//   shf_flg[1:0] in   {sz, sv}
//   ureg_wr_en   in   explicit register write strobe
//   ureg_wr_sel  in   0 = ASTAT, 1 = STKY
//   ureg_wr_dat  in   write data (STKY takes bits [2:0])
//   stk_push     in   push ASTAT onto the status stack
//   stk_pop      in   pop the status stack into ASTAT
//   astat_bts    out  {sz, sv, mv, mn, ac, an, av, az}
//   stky_bts     out  {sos, mos, aos}
//   stk_full     out  stack holds STK_DEPTH entries
//   stk_empty    out  stack holds no entries
//   stk_err      out  one-cycle pulse after an illegal stack operation
// -----------------------------------------------------------------------------
module astat_reg #(
  parameter int STK_DEPTH = 4  // legal range 2..16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alu_flg_en,
  input  logic [3:0] alu_flg,
  input  logic       mul_flg_en,
  input  logic [1:0] mul_flg,
  input  logic       shf_flg_en,
  input  logic [1:0] shf_flg,
  input  logic       ureg_wr_en,
  input  logic       ureg_wr_sel,
  input  logic [7:0] ureg_wr_dat,
  input  logic       stk_push,
  input  logic       stk_pop,
  output logic [7:0] astat_bts,
  output logic [2:0] stky_bts,
  output logic       stk_full,
  output logic       stk_empty,
  output logic       stk_err
);

  localparam int CW = $clog2(STK_DEPTH + 1);

  // Decoded stack operation for this cycle.
  typedef struct packed {
    logic push_ok;
    logic pop_ok;
    logic err;
  } stk_op_t;

  logic [7:0]                  astat_q, astat_d;
  logic [2:0]                  stky_q,  stky_d;
  logic [CW-1:0]               cnt_q,   cnt_d;
  logic                        full_q,  full_d;
  logic                        empty_q, empty_d;
  logic                        err_q,   err_d;
  logic [STK_DEPTH-1:0][7:0]   stk_mem_q, stk_mem_d;

  stk_op_t    op;
  logic [7:0] stk_top;
  logic       wr_astat;
  logic       wr_stky;

  assign wr_astat = ureg_wr_en && !ureg_wr_sel;
  assign wr_stky  = ureg_wr_en &&  ureg_wr_sel;

  // Push and pop in the same cycle are treated as a conflict, not as a
  // swap: neither takes effect and the error pulse fires.
  always_comb begin
    op         = '0;
    op.push_ok = stk_push && !stk_pop && (cnt_q != CW'(STK_DEPTH));
    op.pop_ok  = stk_pop && !stk_push && (cnt_q != '0);
    op.err     = (stk_push || stk_pop) && !op.push_ok && !op.pop_ok;
  end

  // Top-of-stack is entry cnt_q-1. This is a compare-based mux, so an index
  // past the written entries is never formed.
  always_comb begin
    stk_top = '0;
    for (int i = 0; i < STK_DEPTH; i++) begin
      if (cnt_q == CW'(i + 1)) stk_top = stk_mem_q[i];
    end
  end

  // A push stores the current (pre-edge) ASTAT. Same-cycle flag updates go
  // only into ASTAT.
  always_comb begin
    stk_mem_d = stk_mem_q;
    for (int i = 0; i < STK_DEPTH; i++) begin
      if (op.push_ok && (cnt_q == CW'(i))) stk_mem_d[i] = astat_q;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (op.push_ok)     cnt_d = cnt_q + CW'(1);
    else if (op.pop_ok) cnt_d = cnt_q - CW'(1);
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == CW'(STK_DEPTH));
    err_d   = op.err;
  end

  // ASTAT priority: legal pop, then explicit write, then per-group flags.
  always_comb begin
    astat_d = astat_q;
    if (op.pop_ok) begin
      astat_d = stk_top;
    end else if (wr_astat) begin
      astat_d = ureg_wr_dat;
    end else begin
      if (alu_flg_en) astat_d[3:0] = alu_flg;
      if (mul_flg_en) astat_d[5:4] = mul_flg;
      if (shf_flg_en) astat_d[7:6] = shf_flg;
    end
  end

  // Sticky bits see every overflow event, whatever happens to ASTAT. Only a
  // STKY write clears them, and that write beats a same-cycle set.
  always_comb begin
    stky_d = stky_q;
    if (alu_flg_en && alu_flg[1]) stky_d[0] = 1'b1;  // aos <- av
    if (mul_flg_en && mul_flg[1]) stky_d[1] = 1'b1;  // mos <- mv
    if (shf_flg_en && shf_flg[0]) stky_d[2] = 1'b1;  // sos <- sv
    if (wr_stky) stky_d = ureg_wr_dat[2:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      astat_q   <= '0;
      stky_q    <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      err_q     <= 1'b0;
      stk_mem_q <= '0;
    end else begin
      astat_q   <= astat_d;
      stky_q    <= stky_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      err_q     <= err_d;
      stk_mem_q <= stk_mem_d;
    end
  end

  assign astat_bts = astat_q;
  assign stky_bts  = stky_q;
  assign stk_full  = full_q;
  assign stk_empty = empty_q;
  assign stk_err   = err_q;

endmodule

// File: tb/tb_astat_reg.sv
module tb_astat_reg;

  logic       clk;
  logic       reset;
  logic       alu_flg_en;
  logic [3:0] alu_flg;
  logic       mul_flg_en;
  logic [1:0] mul_flg;
  logic       shf_flg_en;
  logic [1:0] shf_flg;
  logic       ureg_wr_en;
  logic       ureg_wr_sel;
  logic [7:0] ureg_wr_dat;
  logic       stk_push;
  logic       stk_pop;
  logic [7:0] astat_bts;
  logic [2:0] stky_bts;
  logic       stk_full;
  logic       stk_empty;
  logic       stk_err;

  int n_chk;
  int n_fail;

  astat_reg #(.STK_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_flg_en (alu_flg_en),
    .alu_flg    (alu_flg),
    .mul_flg_en (mul_flg_en),
    .mul_flg    (mul_flg),
    .shf_flg_en (shf_flg_en),
    .shf_flg    (shf_flg),
    .ureg_wr_en (ureg_wr_en),
    .ureg_wr_sel(ureg_wr_sel),
    .ureg_wr_dat(ureg_wr_dat),
    .stk_push   (stk_push),
    .stk_pop    (stk_pop),
    .astat_bts  (astat_bts),
    .stky_bts   (stky_bts),
    .stk_full   (stk_full),
    .stk_empty  (stk_empty),
    .stk_err    (stk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    alu_flg_en = 0; alu_flg = '0;
    mul_flg_en = 0; mul_flg = '0;
    shf_flg_en = 0; shf_flg = '0;
    ureg_wr_en = 0; ureg_wr_sel = 0; ureg_wr_dat = '0;
    stk_push = 0; stk_pop = 0;
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it and inputs
  // are changed there too, well clear of the next edge.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input logic sel, input logic [7:0] dat);
    ureg_wr_en = 1; ureg_wr_sel = sel; ureg_wr_dat = dat;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    idle();
    reset = 1'b1;
    #3;
    chk("rst_astat", astat_bts, 8'h00);
    chk("rst_stky",  stky_bts,  3'b000);
    chk("rst_empty", stk_empty, 1'b1);
    chk("rst_full",  stk_full,  1'b0);
    chk("rst_err",   stk_err,   1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // ALU group alone: {ac,an,av,az}=0101
    alu_flg_en = 1; alu_flg = 4'b0101;
    step();
    chk("alu_astat", astat_bts, 8'h05);
    chk("alu_stky",  stky_bts,  3'b000);
    // multiplier mn=1 -> bit4
    mul_flg_en = 1; mul_flg = 2'b01;
    step();
    chk("mul_astat", astat_bts, 8'h15);
    chk("mul_stky",  stky_bts,  3'b000);
    // shifter sv=1 -> bit6, sos sticky
    shf_flg_en = 1; shf_flg = 2'b01;
    step();
    chk("shf_astat", astat_bts, 8'h55);
    chk("shf_stky",  stky_bts,  3'b100);
    // sticky survives flag updates that no longer overflow
    shf_flg_en = 1; shf_flg = 2'b10;
    step();
    chk("shf2_astat", astat_bts, 8'h95);
    chk("stky_hold",  stky_bts,  3'b100);
    // STKY clear leaves ASTAT alone
    wr(1'b1, 8'h00);
    step();
    chk("stkyclr_stky",  stky_bts,  3'b000);
    chk("stkyclr_astat", astat_bts, 8'h95);

    // ASTAT write beats ALU flags; av still sets aos
    wr(1'b0, 8'hA0);
    alu_flg_en = 1; alu_flg = 4'b0010;
    step();
    chk("conf_astat", astat_bts, 8'hA0);
    chk("conf_stky",  stky_bts,  3'b001);

    // STKY write 0 beats a same-cycle mv set; mul flags still reach ASTAT
    wr(1'b1, 8'h00);
    mul_flg_en = 1; mul_flg = 2'b10;
    step();
    chk("stkywr_stky",  stky_bts,  3'b000);
    chk("stkywr_astat", astat_bts, 8'hA0);

    // push / overwrite / pop round trip
    wr(1'b0, 8'h3C);
    step();
    chk("rt_set", astat_bts, 8'h3C);
    stk_push = 1;
    step();
    chk("rt_push_empty", stk_empty, 1'b0);
    chk("rt_push_err",   stk_err,   1'b0);
    wr(1'b0, 8'h00);
    step();
    chk("rt_wr", astat_bts, 8'h00);
    chk("rt_wr_err", stk_err, 1'b0);
    stk_pop = 1;
    step();
    chk("rt_pop_astat", astat_bts, 8'h3C);
    chk("rt_pop_empty", stk_empty, 1'b1);
    chk("rt_pop_err",   stk_err,   1'b0);

    // Fill the stack while ALU flags change: each entry keeps pre-edge ASTAT.
    // Stored: 3C,31,32,33; ASTAT ends at 34.
    for (int i = 0; i < 4; i++) begin
      stk_push = 1; alu_flg_en = 1; alu_flg = 4'(i + 1);
      step();
      chk("fill_astat", astat_bts, 8'h30 | 8'(i + 1));
      chk("fill_err",   stk_err,   1'b0);
    end
    chk("fill_full", stk_full, 1'b1);
    stk_push = 1;
    step();
    chk("ovf_err",   stk_err,   1'b1);
    chk("ovf_full",  stk_full,  1'b1);
    chk("ovf_astat", astat_bts, 8'h34);
    step();
    chk("ovf_err_clr", stk_err, 1'b0);
    stk_pop = 1;
    step();
    chk("pop4_astat", astat_bts, 8'h33);
    chk("pop4_full",  stk_full,  1'b0);
    stk_pop = 1;
    step();
    chk("pop3_astat", astat_bts, 8'h32);
    // count is now 2: push+pop together is a conflict
    stk_push = 1; stk_pop = 1;
    step();
    chk("pp_err",   stk_err,   1'b1);
    chk("pp_astat", astat_bts, 8'h32);
    step();
    chk("pp_err_clr", stk_err, 1'b0);
    stk_pop = 1;
    step();
    chk("pop2_astat", astat_bts, 8'h31);
    // pop beats ASTAT write; av still sets aos
    stk_pop = 1; wr(1'b0, 8'hEE);
    alu_flg_en = 1; alu_flg = 4'b0010;
    step();
    chk("popwr_astat", astat_bts, 8'h3C);
    chk("popwr_stky",  stky_bts,  3'b001);
    chk("popwr_empty", stk_empty, 1'b1);
    chk("popwr_err",   stk_err,   1'b0);
    // pop on empty: error, ASTAT unchanged
    stk_pop = 1;
    step();
    chk("udf_err",   stk_err,   1'b1);
    chk("udf_astat", astat_bts, 8'h3C);
    // pop on empty with write: write still lands
    stk_pop = 1; wr(1'b0, 8'h5A);
    step();
    chk("udfwr_err",   stk_err,   1'b1);
    chk("udfwr_astat", astat_bts, 8'h5A);

    // async reset between edges with count=3, astat=FF
    wr(1'b0, 8'hFF);
    step();
    wr(1'b1, 8'h07);
    step();
    for (int i = 0; i < 3; i++) begin
      stk_push = 1;
      step();
    end
    chk("pre_rst_astat", astat_bts, 8'hFF);
    chk("pre_rst_stky",  stky_bts,  3'b111);
    chk("pre_rst_empty", stk_empty, 1'b0);
    stk_push = 1;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_astat", astat_bts, 8'h00);
    chk("arst_stky",  stky_bts,  3'b000);
    chk("arst_empty", stk_empty, 1'b1);
    chk("arst_full",  stk_full,  1'b0);
    chk("arst_err",   stk_err,   1'b0);
    @(posedge clk); #1;
    idle();
    reset = 1'b0;
    alu_flg_en = 1; alu_flg = 4'b0101;
    step();
    chk("post_rst_astat", astat_bts, 8'h05);
    chk("post_rst_empty", stk_empty, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
